mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the single-cycle CPU. It sits directly downstream of the register file read ports and consumes the qa/qb operands.
- It computes MULT/MULTU/DIV/DIVU results into internal HI/LO registers over multiple cycles. The core stalls on busy and reads the results via mfhi/mflo paths.
- It also supports direct mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  request new operation; sampled on rising edge only when busy=0.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  operand rs (regfile qa); multiplicand or dividend.
- b  input  WIDTH  operand rt (regfile qb); multiplier or divisor.
- wr_hi  input  1  mthi write strobe.
- wr_lo  input  1  mtlo write strobe.
- wdata  input  WIDTH  mthi/mtlo data.
- busy  output  1  operation in progress; core must stall mfhi/mflo/new mult-div.
- done  output  1  one-cycle pulse: HI/LO just updated by a completed operation.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, and all internal datapath registers and the counter = 0. Reset takes effect mid-operation too; the aborted result is discarded.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, WIDTH cycles.
  - FIX: busy=1, 1 cycle.
- Transitions:
  - IDLE -> CALC on a rising edge with start=1. On that edge, a, b, and op are latched; signed ops latch absolute values plus sign flags; the counter is loaded with WIDTH.
  - CALC: each edge performs one radix-2 step and decrements the counter. After the WIDTH-th step the state moves to FIX.
  - FIX -> IDLE: on that edge, sign correction is applied and hi/lo are written, busy falls, and done=1 for exactly the following cycle.
- Latency: if start is sampled at edge 0, hi/lo hold the new result and done=1 after edge WIDTH+1 (edge 33 for WIDTH=32). busy is 1 from after edge 0 through edge WIDTH+1.
- Multiply: shift-add, unsigned magnitude, 2*WIDTH-bit product {hi,lo}. MULT negates the product when the operand signs differ.
- Divide: restoring shift-subtract on magnitudes.
  - The quotient truncates toward zero: lo = quotient, hi = remainder.
  - The signed remainder takes the dividend's sign; the quotient is negated when the operand signs differ.
  - -2^(W-1) / -1 (signed): lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b=0), both DIV and DIVU: runs full latency; result lo=0xFFFFFFFF, hi=a (original dividend).
- start while busy=1: ignored; no queuing.
- wr_hi/wr_lo:
  - When busy=0, hi/lo take wdata on the edge; both strobes may fire on the same edge.
  - Ignored while busy=1 and in the FIX cycle.
  - start=1 together with wr_hi/wr_lo in IDLE: start wins and the writes are ignored.
- hi/lo are stable (hold previous values) during CALC; the core may not observe partial results.
- done is never asserted by mthi/mtlo writes.
- Back-to-back: start may be asserted in the done cycle (busy=0). It is accepted, and done drops the next cycle.

Test Plan:
- Reset mid-op: start MULTU 7*9, pull clrn low at cycle 10 -> hi=lo=0, busy=0, done=0 immediately; no done pulse follows.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle; busy high for edges 1..33.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Divide by zero DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234 at normal latency.
- Handshake: start during busy with different operands ignored (result matches first op); wr_hi=1 wdata=0xAA during busy ignored; wr_hi+wr_lo in IDLE -> hi=lo=wdata next edge, done stays 0; start in done cycle accepted, busy=1 next cycle.

Source files
------------

// File: rtl/mdu_if.sv
// Core <-> multiply/divide unit signal bundle: operation request, mthi/mtlo writes, HI/LO readback.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign correction in a final fix-up cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  clrn,
  mdu_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0] m_q, m_d;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;       // original dividend, returned on divide by zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;     // operand a negative (signed ops only)
  logic             sb_q, sb_d;     // operand b negative (signed ops only)
  logic             done_q, done_d;

  logic             in_signed, in_sa, in_sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Magnitudes and sign flags of the operands currently on the bus
  always_comb begin
    in_signed = ~bus.op[0];
    in_sa     = in_signed & bus.a[WIDTH-1];
    in_sb     = in_signed & bus.b[WIDTH-1];
    abs_a     = in_sa ? -bus.a : bus.a;
    abs_b     = in_sb ? -bus.b : bus.b;
  end

  // One radix-2 step for each algorithm, plus the sign-corrected product
  always_comb begin
    sum      = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    shifted  = {acc_q, q_q[WIDTH-1]};
    diff     = shifted - {1'b0, m_q};
    prod     = {acc_q, q_q};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCalc;
          cnt_d   = CntW'(WIDTH);
          op_d    = bus.op;
          sa_d    = in_sa;
          sb_d    = in_sb;
          a_d     = bus.a;
          acc_d   = '0;
          if (bus.op[1]) begin
            q_d = abs_a;
            m_d = abs_b;
          end else begin
            q_d = abs_b;
            m_d = abs_a;
          end
        end else begin
          // Register writes only when no operation is being launched
          if (bus.wr_hi) hi_d = bus.wdata;
          if (bus.wr_lo) lo_d = bus.wdata;
        end
      end

      StCalc: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[1]) begin
          // diff[WIDTH] set means the trial subtraction borrowed: restore
          acc_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          acc_d = sum[WIDTH:1];
          q_d   = {sum[0], q_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(1)) state_d = StFix;
      end

      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (m_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = (sa_q ^ sb_q) ? -q_q : q_q;
            hi_d = sa_q ? -acc_q : acc_q;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed table, handshake corner cases, random vs model.
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic with the architectural special cases
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int     qs, rs;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qs = $signed(a) / $signed(b);
        rs = $signed(a) % $signed(b);
        return {rs, qs};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Launch an op from idle and follow it to its done cycle; leaves time in the done cycle
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] req, input bit interfere);
    bit ok;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    check({name, " busy_done_after_start"}, {62'h0, bus.busy, bus.done}, 64'h2);
    ok = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      if (interfere && e == 5) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.a     = a ^ 32'h0F0F_1234;
        bus.b     = b + 32'd3;
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hAA;
      end
      if (interfere && e == 6) begin
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
      end
      tick();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo)
        ok = 1'b0;
    end
    check({name, " busy_and_stable_in_calc"}, {63'h0, ok}, 64'h1);
    if (interfere) begin
      // Strobes land on the fix-up edge and must be dropped
      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h55;
    end
    tick();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    exp_hi = req[63:32];
    exp_lo = req[31:0];
    check({name, " busy_done_at_end"}, {62'h0, bus.busy, bus.done}, 64'h1);
    check({name, " result"}, {bus.hi, bus.lo}, req);
  endtask

  task automatic idle_tick(input string name);
    tick();
    check({name, " done_one_cycle"}, {62'h0, bus.busy, bus.done}, 64'h0);
  endtask

  initial begin
    bit          quiet;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9] = '{2'b01, 32'd7,         32'd9,         32'h0000_0000, 32'd63};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    clrn = 1'b1;
    tick();
    check("after_reset_release", {bus.busy, bus.done, bus.hi, bus.lo}, '0);

    // mthi alone
    bus.wr_hi = 1'b1;
    bus.wdata = 32'hA5A5_0001;
    tick();
    bus.wr_hi = 1'b0;
    exp_hi = 32'hA5A5_0001;
    check("mthi_only", {bus.hi, bus.lo}, {exp_hi, exp_lo});

    // mthi + mtlo on the same edge, no done pulse
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h1357_9BDF;
    tick();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    exp_hi = 32'h1357_9BDF;
    exp_lo = 32'h1357_9BDF;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    check("mthi_mtlo_no_done", {63'h0, bus.done}, 64'h0);

    // start with write strobes: start wins; then reset mid-operation
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    check("start_beats_write", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    check("start_beats_write_busy", {63'h0, bus.busy}, 64'h1);
    repeat (9) tick();
    clrn = 1'b0;
    #1;
    check("reset_mid_op", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    exp_hi = '0;
    exp_lo = '0;
    tick();
    clrn = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    check("no_done_after_abort", {63'h0, quiet}, 64'h1);

    // Directed table; first entry also fires start/mthi/mtlo while busy and in fix-up
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].hi, vecs[i].lo}, i == 0);
      idle_tick($sformatf("vec%0d", i));
    end

    // Back-to-back: next start issued in the done cycle
    run_op("b2b_first", 2'b11, 32'd1000, 32'd33, model(2'b11, 32'd1000, 32'd33), 1'b0);
    run_op("b2b_second", 2'b00, 32'hFFFF_FF00, 32'd77,
           model(2'b00, 32'hFFFF_FF00, 32'd77), 1'b0);
    idle_tick("b2b_second");

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
             model(rop, ra, rb), 1'b0);
      if ($urandom_range(0, 1) == 0) idle_tick($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
